da_interp_8bit: RTL and testbench
=================================

# da_interp_8bit

Linear-interpolation upsampler for the 8-bit DAC output path. It accepts a slow stream of 8-bit samples over a valid/ready handshake and drives one interpolated 8-bit code to the DA converter every clock. Each input step is spread over L clocks. It sits between the sample source (waveform generator or processing chain) and the DAC pins.

## Interface
- L, 8, interpolation factor; power of 2, 2..64; S = log2(L)
- clk  in  1  DA clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- s_data  in  8  unsigned input sample
- s_valid  in  1  s_data valid
- s_ready  out  1  block can accept a sample; registered
- da_data  out  8  unsigned DAC code; registered
- seg_start  out  1  one-cycle pulse when da_data carries the first point (k=0) of a new segment
- underrun  out  1  one-cycle pulse on entry to HOLD

## Operation
- Handshake: a sample transfers on an edge where s_valid && s_ready. s_ready depends on registers only, never on s_valid.
- Registers:
  - P (segment start)
  - C (segment end)
  - NXT plus nxt_valid (one-entry buffer)
  - phase counter k (S bits)
  - signed accumulator acc (9+S bits)
- States:
  - IDLE: s_ready=1. On a transfer, P<=s_data and go to FILL.
  - FILL: s_ready=1. On a transfer, C<=s_data, k<=0, acc<=P<<S, and go to RUN.
  - RUN: da_data <= acc>>>S (arithmetic shift, floor). acc += (C−P) as signed 9-bit. k++.
    - Incoming samples go to NXT. s_ready = !nxt_valid.
    - Point k is P + floor(k·(C−P)/L), so k=0 gives P exactly. The result always lies within [min(P,C), max(P,C)]; no clipping is needed.
  - Segment end (the cycle outputting k=L−1):
    - If nxt_valid: P<=C, C<=NXT, nxt_valid<=0, acc<=C<<S, k<=0, stay in RUN.
    - Else: go to HOLD.
  - HOLD: da_data <= C (held). underrun pulses on the first HOLD cycle only. s_ready = !nxt_valid.
    - A transfer fills NXT.
    - On the next edge with nxt_valid: start a segment as above (P<=C, C<=NXT), go to RUN.
- Simultaneous events:
  - A segment end that consumes NXT and an s_valid arriving in the same cycle: no transfer that cycle, because s_ready was 0. s_ready returns to 1 on the following edge.
  - A segment end that consumes NXT and a transfer into NXT never coincide, since s_ready=0 whenever nxt_valid=1.
- Throughput: sustains one sample per L clocks without underrun if the source responds within L−1 cycles of s_ready.

## Timing
- Reset (rst_n low at an edge):
  - state=IDLE
  - da_data=0, s_ready=0, seg_start=0, underrun=0
  - P, C, NXT, acc, k cleared; nxt_valid=0
  - s_ready rises on the first edge with rst_n high.
- Reset mid-operation: same as above at the next edge. A buffered NXT is discarded, and da_data drops to 0.
- In IDLE/FILL, da_data holds its last value (0 after reset).
- The second sample transfers at edge t. On edge t+1, da_data=P and seg_start=1. Point k appears at edge t+1+k.
- Back-to-back segments: point k=0 of the new segment follows k=L−1 of the old one on the next edge, with no gap.
- HOLD exit: the sample transfers at edge h. On h+1, nxt_valid=1. On h+2, da_data=C (new P) and seg_start=1.
- underrun and seg_start are registered and aligned with the da_data they describe.

## Test plan
- Reset: hold rst_n=0 for 3 clocks with s_valid=1 -> da_data=0, s_ready=0, no pulses, no sample taken. After release, s_ready=1 on the next edge.
- Ramp up (L=4), samples 0, 100, 200 supplied on demand:
  - da_data 0,25,50,75,100,125,150,175, then 200 held
  - seg_start at the 0 and 100 points
  - one underrun pulse on the first 200
- Floor rounding (L=4), 10 then 0 -> da_data 10,7,5,2, then HOLD at 0 with an underrun pulse.
- Underrun recovery: in HOLD at 200, supply 40 -> one extra 200 cycle, then 200,160,120,80 with seg_start on the first 200, then HOLD at 40.
- Backpressure (L=8): s_valid held high with data incrementing on each transfer ->
  - exactly one transfer per 8 clocks in steady state
  - s_ready low whenever nxt_valid
  - no sample dropped or duplicated, checked against a reference model
  - no underrun
- Reset mid-RUN: assert rst_n=0 at k=2 with NXT full -> da_data=0 on the next edge; the buffered sample is lost. A new stream restarts from IDLE correctly.

Source files
------------

// File: rtl/da_interp_8bit.sv
// Linear-interpolation upsampler feeding the 8-bit DAC.
// Spreads each input step over L clocks using a fixed-point accumulator.
module da_interp_8bit #(
    parameter int unsigned L = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic [7:0] da_data,
    output logic       seg_start,
    output logic       underrun
);

    localparam int S  = $clog2(L);
    localparam int AW = S + 9;
    localparam logic [S-1:0] K_LAST = S'(L - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FILL = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    logic [1:0]           state, state_n;
    logic [7:0]           p, p_n;
    logic [7:0]           c, c_n;
    logic [7:0]           nxt, nxt_n;
    logic                 nxt_valid, nxt_valid_n;
    logic [S-1:0]         k, k_n;
    logic signed [AW-1:0] acc, acc_n;
    logic [7:0]           da_n;
    logic                 seg_start_n;
    logic                 underrun_n;
    logic                 hold_first, hold_first_n;
    logic                 s_ready_n;

    logic                 transfer;
    logic [8:0]           diff;
    logic signed [AW-1:0] diff_ext;
    logic signed [AW-1:0] acc_sh;
    logic signed [AW-1:0] c_scaled;
    logic signed [AW-1:0] p_scaled;
    logic                 unused_bits;

    assign transfer = s_valid && s_ready;
    assign diff     = {1'b0, c} - {1'b0, p};
    assign diff_ext = {{S{diff[8]}}, diff};
    assign acc_sh   = acc >>> S;
    assign c_scaled = {1'b0, c, {S{1'b0}}};
    assign p_scaled = {1'b0, p, {S{1'b0}}};

    // acc never leaves [min(P,C), max(P,C)] << S, so the top bits are always zero
    assign unused_bits = ^acc_sh[AW-1:8];

    always_comb begin
        state_n      = state;
        p_n          = p;
        c_n          = c;
        nxt_n        = nxt;
        nxt_valid_n  = nxt_valid;
        k_n          = k;
        acc_n        = acc;
        da_n         = da_data;
        seg_start_n  = 1'b0;
        underrun_n   = 1'b0;
        hold_first_n = hold_first;

        case (state)
            IDLE: begin
                if (transfer) begin
                    p_n     = s_data;
                    state_n = FILL;
                end
            end

            FILL: begin
                if (transfer) begin
                    c_n     = s_data;
                    k_n     = '0;
                    acc_n   = p_scaled;
                    state_n = RUN;
                end
            end

            RUN: begin
                da_n        = acc_sh[7:0];
                seg_start_n = (k == '0);
                acc_n       = acc + diff_ext;
                k_n         = k + 1'b1;
                if (transfer) begin
                    nxt_n       = s_data;
                    nxt_valid_n = 1'b1;
                end
                if (k == K_LAST) begin
                    if (nxt_valid) begin
                        p_n         = c;
                        c_n         = nxt;
                        nxt_valid_n = 1'b0;
                        acc_n       = c_scaled;
                        k_n         = '0;
                    end else begin
                        state_n      = HOLD;
                        hold_first_n = 1'b1;
                    end
                end
            end

            HOLD: begin
                da_n         = c;
                underrun_n   = hold_first;
                hold_first_n = 1'b0;
                if (transfer) begin
                    nxt_n       = s_data;
                    nxt_valid_n = 1'b1;
                end
                if (nxt_valid) begin
                    p_n         = c;
                    c_n         = nxt;
                    nxt_valid_n = 1'b0;
                    acc_n       = c_scaled;
                    k_n         = '0;
                    state_n     = RUN;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        // Ready is a pure function of next-state registers, never of s_valid
        s_ready_n = (state_n == IDLE) || (state_n == FILL) || !nxt_valid_n;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            p          <= '0;
            c          <= '0;
            nxt        <= '0;
            nxt_valid  <= 1'b0;
            k          <= '0;
            acc        <= '0;
            da_data    <= '0;
            seg_start  <= 1'b0;
            underrun   <= 1'b0;
            hold_first <= 1'b0;
            s_ready    <= 1'b0;
        end else begin
            state      <= state_n;
            p          <= p_n;
            c          <= c_n;
            nxt        <= nxt_n;
            nxt_valid  <= nxt_valid_n;
            k          <= k_n;
            acc        <= acc_n;
            da_data    <= da_n;
            seg_start  <= seg_start_n;
            underrun   <= underrun_n;
            hold_first <= hold_first_n;
            s_ready    <= s_ready_n;
        end
    end

endmodule

// File: tb/tb_da_interp_8bit.sv
// Directed bench for da_interp_8bit with L=4 and L=8 instances.
// Expected codes are hand-derived or computed from the transfer log.
module tb_da_interp_8bit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst4, s_valid4, s_ready4, seg4, und4;
    logic [7:0] s_data4, da4;
    logic       rst8, s_valid8, s_ready8, seg8, und8;
    logic [7:0] s_data8, da8;

    da_interp_8bit #(.L(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst4),
        .s_data    (s_data4),
        .s_valid   (s_valid4),
        .s_ready   (s_ready4),
        .da_data   (da4),
        .seg_start (seg4),
        .underrun  (und4)
    );

    da_interp_8bit #(.L(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst8),
        .s_data    (s_data8),
        .s_valid   (s_valid8),
        .s_ready   (s_ready8),
        .da_data   (da8),
        .seg_start (seg8),
        .underrun  (und8)
    );

    int tests = 0;
    int fails = 0;

    int ramp_da[9]  = '{25, 50, 75, 100, 125, 150, 175, 200, 200};
    int ramp_seg[9] = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
    int ramp_und[9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
    int rec_da[7]   = '{200, 200, 160, 120, 80, 40, 40};
    int rec_seg[7]  = '{0, 1, 0, 0, 0, 0, 0};
    int rec_und[7]  = '{0, 0, 0, 0, 0, 1, 0};
    int flr_da[6]   = '{10, 7, 5, 2, 0, 0};
    int flr_seg[6]  = '{1, 0, 0, 0, 0, 0};
    int flr_und[6]  = '{0, 0, 0, 0, 1, 0};
    int rst_da[9]   = '{200, 190, 180, 170, 160, 150, 140, 130, 120};
    int rst_seg[9]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    int rst_und[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] smp[$];
        logic       xfer;
        int         j, seg, kk, pv, cv, ev;

        rst4 = 1'b0; s_valid4 = 1'b1; s_data4 = 8'd55;
        rst8 = 1'b0; s_valid8 = 1'b0; s_data8 = 8'd0;

        // Reset with s_valid high
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_da", da4, 0);
            chk("rst_ready", s_ready4, 0);
            chk("rst_seg", seg4, 0);
            chk("rst_und", und4, 0);
        end
        rst4 = 1'b1; s_valid4 = 1'b0;
        step();
        chk("rel_ready", s_ready4, 1);
        chk("rel_da", da4, 0);

        // Ramp 0,100,200 at L=4
        s_valid4 = 1'b1; s_data4 = 8'd0;
        step();
        chk("fill_ready", s_ready4, 1);
        s_data4 = 8'd100;
        step();
        chk("run_ready", s_ready4, 1);
        s_data4 = 8'd200;
        step();
        chk("ramp_da0", da4, 0);
        chk("ramp_seg0", seg4, 1);
        chk("ramp_und0", und4, 0);
        chk("ramp_nxt_ready", s_ready4, 0);
        s_valid4 = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step();
            chk("ramp_da", da4, ramp_da[i]);
            chk("ramp_seg", seg4, ramp_seg[i]);
            chk("ramp_und", und4, ramp_und[i]);
        end

        // Underrun recovery from HOLD at 200
        s_valid4 = 1'b1; s_data4 = 8'd40;
        step();
        chk("rec_da_h", da4, 200);
        chk("rec_und_h", und4, 0);
        chk("rec_ready_h", s_ready4, 0);
        s_valid4 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            chk("rec_da", da4, rec_da[i]);
            chk("rec_seg", seg4, rec_seg[i]);
            chk("rec_und", und4, rec_und[i]);
        end

        // Floor rounding 10 -> 0
        rst4 = 1'b0;
        step();
        chk("rst2_da", da4, 0);
        chk("rst2_ready", s_ready4, 0);
        rst4 = 1'b1;
        step();
        chk("rel2_ready", s_ready4, 1);
        s_valid4 = 1'b1; s_data4 = 8'd10;
        step();
        s_data4 = 8'd0;
        step();
        s_valid4 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("flr_da", da4, flr_da[i]);
            chk("flr_seg", seg4, flr_seg[i]);
            chk("flr_und", und4, flr_und[i]);
        end

        // Backpressure at L=8 with s_valid held high
        step();
        rst8 = 1'b1; s_valid8 = 1'b1; s_data8 = 8'd23;
        step();
        chk("bp_rel_ready", s_ready8, 1);
        for (int cyc = 0; cyc <= 100; cyc++) begin
            xfer = s_ready8;
            if (xfer) smp.push_back(s_data8);
            chk("bp_xfer", xfer, (cyc < 2) || (((cyc - 2) % 8) == 0));
            step();
            if (xfer) s_data8 = s_data8 + 8'd23;
            if (cyc >= 2) begin
                j   = cyc - 2;
                seg = j / 8;
                kk  = j % 8;
                if (seg + 1 < smp.size()) begin
                    pv = int'(smp[seg]);
                    cv = int'(smp[seg + 1]);
                    ev = (pv * 8 + kk * (cv - pv)) / 8;
                    chk("bp_da", da8, ev);
                end else begin
                    chk("bp_log", smp.size(), seg + 2);
                end
                chk("bp_seg", seg8, kk == 0);
                chk("bp_und", und8, 0);
            end
        end

        // Reset at k=2 with NXT full, then restart
        chk("mid_ready", s_ready8, 0);
        rst8 = 1'b0; s_data8 = 8'd200;
        step();
        chk("mid_da", da8, 0);
        chk("mid_ready_rst", s_ready8, 0);
        chk("mid_seg", seg8, 0);
        rst8 = 1'b1;
        step();
        chk("mid_rel_ready", s_ready8, 1);
        chk("mid_rel_da", da8, 0);
        step();
        s_data8 = 8'd120;
        step();
        s_valid8 = 1'b0;
        chk("mid_run_ready", s_ready8, 1);
        for (int i = 0; i < 9; i++) begin
            step();
            chk("mid_da_seq", da8, rst_da[i]);
            chk("mid_seg_seq", seg8, rst_seg[i]);
            chk("mid_und_seq", und8, rst_und[i]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
